// File: rtl/prng_req_arbiter.sv
// Shares one free-running PRNG word stream between NUM_REQ consumers: discards
// WARMUP words after reset/reseed, then grants each fresh word to one requester round-robin.
module prng_arb_lane #(
  parameter int PTR_W = 2,
  parameter int IDX   = 0
) (
  input  logic [PTR_W-1:0] rr_ptr_i,
  input  logic             req_i,
  output logic             hi_o
);
  // Request at or above the round-robin pointer: wins before any wrapped-around request.
  assign hi_o = req_i & ({1'b0, rr_ptr_i} <= (PTR_W+1)'(IDX));
endmodule

module prng_req_arbiter #(
  parameter int N       = 32,
  parameter int NUM_REQ = 4,
  parameter int WARMUP  = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       rnd_in,
  input  logic               rnd_valid,
  input  logic               reseed,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [N-1:0]       data_out,
  output logic               data_valid,
  output logic               ready,
  output logic [CNT_W-1:0]   words_served
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int WC_W  = 16;

  typedef enum logic [0:0] {ST_WARMUP, ST_SERVE} state_t;

  state_t             state_q, state_d;
  logic [WC_W-1:0]    wcnt_q, wcnt_d;
  logic [PTR_W-1:0]   rr_q, rr_d, win;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, hi_req;
  logic [N-1:0]       data_q, data_d;
  logic               dv_q, dv_d;
  logic [CNT_W-1:0]   served_q, served_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    prng_arb_lane #(.PTR_W(PTR_W), .IDX(i)) u_lane (
      .rr_ptr_i (rr_q),
      .req_i    (req[i]),
      .hi_o     (hi_req[i])
    );
  end

  // Lowest set bit of req, overridden by lowest set bit at/above rr_q if any.
  always_comb begin
    win = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) if (req[i])    win = PTR_W'(i);
    for (int i = NUM_REQ-1; i >= 0; i--) if (hi_req[i]) win = PTR_W'(i);
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    rr_d     = rr_q;
    gnt_d    = '0;
    dv_d     = 1'b0;
    data_d   = data_q;
    served_d = served_q;
    if (reseed) begin
      state_d = ST_WARMUP;
      wcnt_d  = '0;
    end else begin
      case (state_q)
        ST_WARMUP: begin
          if (rnd_valid) begin
            if (wcnt_q == WC_W'(WARMUP-1)) begin
              state_d = ST_SERVE;
              wcnt_d  = '0;
            end else begin
              wcnt_d = wcnt_q + WC_W'(1);
            end
          end
        end
        ST_SERVE: begin
          if (rnd_valid && (|req)) begin
            gnt_d  = NUM_REQ'(1) << win;
            data_d = rnd_in;
            dv_d   = 1'b1;
            rr_d   = (win == PTR_W'(NUM_REQ-1)) ? '0 : win + PTR_W'(1);
            if (served_q != '1) served_d = served_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_WARMUP;
      wcnt_q   <= '0;
      rr_q     <= '0;
      gnt_q    <= '0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      served_q <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      data_q   <= data_d;
      dv_q     <= dv_d;
      served_q <= served_d;
    end
  end

  assign gnt          = gnt_q;
  assign data_out     = data_q;
  assign data_valid   = dv_q;
  assign ready        = (state_q == ST_SERVE);
  assign words_served = served_q;
endmodule

// File: tb/tb_prng_req_arbiter.sv
// Directed + randomized bench for prng_req_arbiter against a behavioural model.
module tb_prng_req_arbiter;
  localparam int N  = 32;
  localparam int NR = 4;
  localparam int WU = 4;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  rnd_in;
  logic          rnd_valid;
  logic          reseed;
  logic [NR-1:0] req;
  logic [NR-1:0] gnt;
  logic [N-1:0]  data_out;
  logic          data_valid;
  logic          ready;
  logic [CW-1:0] words_served;

  prng_req_arbiter #(.N(N), .NUM_REQ(NR), .WARMUP(WU), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .rnd_in       (rnd_in),
    .rnd_valid    (rnd_valid),
    .reseed       (reseed),
    .req          (req),
    .gnt          (gnt),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .ready        (ready),
    .words_served (words_served)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  bit            m_serve;
  int            m_wcnt;
  int            m_rr;
  int            m_served;
  logic [NR-1:0] m_gnt;
  logic [N-1:0]  m_data;
  bit            m_dv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_serve = 0; m_wcnt = 0; m_rr = 0; m_served = 0;
    m_gnt = '0; m_data = '0; m_dv = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt"},   64'(gnt),          64'(m_gnt));
    chk({tag, ".dv"},    64'(data_valid),   64'(m_dv));
    chk({tag, ".data"},  64'(data_out),     64'(m_data));
    chk({tag, ".ready"}, 64'(ready),        64'(m_serve));
    chk({tag, ".cnt"},   64'(words_served), 64'(m_served));
  endtask

  // One clock cycle: drive inputs, advance model, check after the edge.
  task automatic step(input logic [NR-1:0] rq, input bit vld, input bit rs, input string tag);
    logic [N-1:0] w;
    int win;
    w = $urandom;
    req = rq; rnd_valid = vld; reseed = rs; rnd_in = w;
    m_gnt = '0; m_dv = 0;
    if (rs) begin
      m_serve = 0; m_wcnt = 0;
    end else if (!m_serve) begin
      if (vld) begin
        m_wcnt++;
        if (m_wcnt == WU) begin m_serve = 1; m_wcnt = 0; end
      end
    end else if (vld && rq != 0) begin
      win = -1;
      for (int k = 0; k < NR; k++)
        if (win < 0 && rq[(m_rr + k) % NR]) win = (m_rr + k) % NR;
      m_gnt = NR'(1) << win;
      m_data = w;
      m_dv = 1;
      m_rr = (win + 1) % NR;
      if (m_served < SAT) m_served++;
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    logic [N-1:0] held;
    reset = 1'b1; req = '0; rnd_valid = 1'b0; reseed = 1'b0; rnd_in = '0;
    model_reset();
    #1;
    check_all("reset");
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;

    // Warm-up: 4 words discarded, ready after 4th, first grant on 5th word
    for (int i = 0; i < WU; i++) step(4'b1111, 1, 0, "warmup");
    step(4'b1111, 1, 0, "first_gnt");
    chk("first_gnt_onehot", 64'(gnt), 64'(4'b0001));

    // Round-robin fairness
    for (int i = 0; i < 4; i++) step(4'b1111, 1, 0, "rr");

    // Sparse requesters, then requests drop
    for (int i = 0; i < 3; i++) step(4'b1010, 1, 0, "sparse");
    held = data_out;
    step(4'b0000, 1, 0, "no_req");
    chk("no_req_hold", 64'(data_out), 64'(held));

    // rnd_valid gaps
    step(4'b0001, 1, 0, "gap1");
    step(4'b0001, 0, 0, "gap2");
    step(4'b0001, 0, 0, "gap3");
    step(4'b0001, 1, 0, "gap4");

    // Reseed in a grant cycle
    step(4'b1111, 1, 1, "reseed");
    for (int i = 0; i < WU; i++) step(4'b1111, 1, 0, "rewarm");
    for (int i = 0; i < 3; i++) step(4'b1111, 1, 0, "resume");

    // Reseed during warm-up restarts the count
    step(4'b1111, 1, 1, "reseed2");
    step(4'b1111, 1, 0, "rw_a");
    step(4'b1111, 1, 1, "reseed3");
    for (int i = 0; i < WU + 2; i++) step(4'b0110, 1, 0, "rw_b");

    // Asynchronous reset with a grant in flight
    step(4'b1111, 1, 0, "pre_areset");
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("areset");
    @(posedge clk); #1;
    check_all("areset_hold");
    reset = 1'b0;
    for (int i = 0; i < WU; i++) step(4'b1111, 1, 0, "warmup2");

    // Saturation: 20 grants
    for (int i = 0; i < 20; i++) step(4'b1111, 1, 0, "sat");
    chk("sat_value", 64'(words_served), 64'(SAT));

    // Randomized traffic
    for (int i = 0; i < 150; i++)
      step(NR'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 24) == 0), "rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
